// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-port SDR SDRAM controller with power-up init, auto-refresh
// and single-word read/write accesses using auto-precharge.
module sdram_ctrl #(
  parameter int INIT_CYCLES = 20000,
  parameter int REFRESH_CYCLES = 750,
  parameter int T_RP = 2,
  parameter int T_RCD = 2,
  parameter int T_RC = 7,
  parameter int CAS = 2,
  parameter logic [12:0] MODE = 13'h020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_mask,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        init_done,
  output logic        sdram_cke,
  output logic        sdram_csn,
  output logic        sdram_rasn,
  output logic        sdram_casn,
  output logic        sdram_wen,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dout,
  input  logic [15:0] sdram_din,
  output logic        sdram_den
);
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101, C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_ACT, S_RW, S_WAIT, S_REFRESH
  } state_t;
  state_t r_state, w_next;
  logic [15:0] r_cnt, w_load, r_rcnt;
  logic        w_done, w_enter, w_wr, w_rd, r_pend, r_write;
  logic [10:0] r_col_bank;
  logic [15:0] r_wdata;
  logic [1:0]  r_mask, w_ba, w_dqm;
  logic [12:0] w_a;
  logic [3:0]  w_cmd;
  logic [CAS:0] r_rd;
  assign w_done = r_cnt == 16'd0;
  assign w_enter = w_next != r_state;
  assign req_ready = r_state == S_IDLE && !r_pend && !reset;
  // Each state's counter holds its remaining cycles; the command goes out on entry.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_INIT_WAIT;
      r_cnt <= 16'(INIT_CYCLES);
    end else begin
      r_state <= w_next;
      r_cnt <= w_enter ? w_load : (w_done ? r_cnt : r_cnt - 16'd1);
    end
  always_comb begin
    w_next = r_state;
    w_load = 16'd0;
    case (r_state)
      S_INIT_WAIT: w_next = w_done ? S_INIT_PRE : S_INIT_WAIT;
      S_INIT_PRE:  w_next = w_done ? S_INIT_REF1 : S_INIT_PRE;
      S_INIT_REF1: w_next = w_done ? S_INIT_REF2 : S_INIT_REF1;
      S_INIT_REF2: w_next = w_done ? S_INIT_MRS : S_INIT_REF2;
      S_INIT_MRS:  w_next = w_done ? S_IDLE : S_INIT_MRS;
      S_IDLE:      w_next = r_pend ? S_REFRESH : (req_valid ? S_ACT : S_IDLE);
      S_ACT:       w_next = w_done ? S_RW : S_ACT;
      S_RW:        w_next = S_WAIT;
      S_WAIT:      w_next = w_done ? S_IDLE : S_WAIT;
      S_REFRESH:   w_next = S_WAIT;
      default:     w_next = S_INIT_WAIT;
    endcase
    case (w_next)
      S_INIT_PRE, S_INIT_MRS:  w_load = 16'(T_RP);
      S_INIT_REF1, S_INIT_REF2: w_load = 16'(T_RC);
      S_ACT:  w_load = 16'(T_RCD - 1);
      S_WAIT: w_load = r_state == S_REFRESH ? 16'(T_RC - 1) : 16'(T_RC - T_RCD - 2);
      default: w_load = 16'd0;
    endcase
  end
  always_comb begin
    w_cmd = C_NOP;
    w_a = sdram_a;
    w_ba = sdram_ba;
    if (w_enter)
      case (w_next)
        S_INIT_PRE: begin w_cmd = C_PRE; w_a = 13'h0400; end
        S_INIT_REF1, S_INIT_REF2, S_REFRESH: w_cmd = C_REF;
        S_INIT_MRS: begin w_cmd = C_MRS; w_a = MODE; w_ba = 2'b00; end
        S_ACT: begin w_cmd = C_ACT; w_a = req_addr[23:11]; w_ba = req_addr[10:9]; end
        S_RW: begin
          w_cmd = r_write ? C_WRITE : C_READ;
          w_a = {4'b0010, r_col_bank[8:0]};
          w_ba = r_col_bank[10:9];
        end
        default: w_cmd = C_NOP;
      endcase
    w_wr = w_enter && w_next == S_RW && r_write;
    w_rd = w_enter && w_next == S_RW && !r_write;
    w_dqm = w_wr ? ~r_mask : ((w_rd || |r_rd[CAS-1:0]) ? 2'b00 : 2'b11);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_col_bank <= '0;
      r_wdata <= '0;
      r_mask <= '0;
      r_write <= 1'b0;
    end else if (req_valid && req_ready) begin
      r_col_bank <= req_addr[10:0];
      r_wdata <= req_wdata;
      r_mask <= req_mask;
      r_write <= req_write;
    end
  // A pending refresh is only cleared by leaving IDLE, which always means issuing REF.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_rcnt <= 16'(REFRESH_CYCLES - 1);
      r_pend <= 1'b0;
    end else if (init_done) begin
      r_rcnt <= r_rcnt == 16'd0 ? 16'(REFRESH_CYCLES - 1) : r_rcnt - 16'd1;
      r_pend <= r_rcnt == 16'd0 || (r_pend && r_state != S_IDLE);
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sdram_cke <= 1'b0;
      {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} <= 4'b1111;
      sdram_a <= '0;
      sdram_ba <= '0;
      sdram_dqm <= 2'b11;
      sdram_den <= 1'b0;
      sdram_dout <= '0;
      r_rd <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      sdram_cke <= 1'b1;
      {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} <= w_cmd;
      sdram_a <= w_a;
      sdram_ba <= w_ba;
      sdram_dqm <= w_dqm;
      sdram_den <= w_wr;
      sdram_dout <= w_wr ? r_wdata : sdram_dout;
      r_rd <= {r_rd[CAS-1:0], w_rd};
      resp_valid <= r_rd[CAS];
      resp_rdata <= r_rd[CAS] ? sdram_din : resp_rdata;
      init_done <= init_done || w_next == S_IDLE;
    end
endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: directed bench for sdram_ctrl with a small behavioural SDRAM
// that answers READs CAS cycles after the command.
module tb_sdram_ctrl;
  localparam int IC = 20, RC = 200, CASL = 2;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] req_mask = '0;
  logic resp_valid, init_done, sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen, sdram_den;
  logic [15:0] resp_rdata, sdram_dout;
  logic [15:0] sdram_din = '0;
  logic [12:0] sdram_a;
  logic [1:0] sdram_ba, sdram_dqm;
  logic [3:0] cmd;
  assign cmd = {sdram_csn, sdram_rasn, sdram_casn, sdram_wen};
  sdram_ctrl #(.INIT_CYCLES(IC), .REFRESH_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .init_done(init_done),
    .sdram_cke(sdram_cke), .sdram_csn(sdram_csn), .sdram_rasn(sdram_rasn),
    .sdram_casn(sdram_casn), .sdram_wen(sdram_wen), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
    .sdram_dqm(sdram_dqm), .sdram_dout(sdram_dout), .sdram_din(sdram_din), .sdram_den(sdram_den)
  );
  always #5 clock = ~clock;
  logic [15:0] mem [int];
  logic [12:0] row_of [4];
  logic [15:0] rd_data, old;
  int rd_cnt = 0, n_ref = 0, key;
  always @(posedge clock or posedge reset)
    if (reset) rd_cnt = 0;
    else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) sdram_din <= rd_data;
      end
      key = int'({sdram_ba, row_of[sdram_ba], sdram_a[8:0]});
      case (cmd)
        ACT: row_of[sdram_ba] = sdram_a;
        WR: begin
          old = mem.exists(key) ? mem[key] : 16'h0000;
          mem[key] = {sdram_dqm[1] ? old[15:8] : sdram_dout[15:8], sdram_dqm[0] ? old[7:0] : sdram_dout[7:0]};
        end
        RD: begin
          rd_data = mem.exists(key) ? mem[key] : 16'h0000;
          rd_cnt = CASL - 1;
        end
        REF: n_ref++;
        default: ;
      endcase
    end
  int n_tests = 0, n_fail = 0, cyc = 0, cyc_init = 0;
  logic [3:0] act_cmd, rw_cmd;
  logic [12:0] act_a, rw_a;
  logic [1:0] act_ba, rw_dqm, dqm_during, dqm_after;
  logic rw_den;
  logic [15:0] rw_dout, rd_val;
  int lat;
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_cke"}, 32'(sdram_cke), 0);
    chk({tag, "_cmd"}, 32'(cmd), 32'hF);
    chk({tag, "_a_ba"}, 32'({sdram_a, sdram_ba}), 0);
    chk({tag, "_dqm_den"}, 32'({sdram_dqm, sdram_den}), 32'h6);
    chk({tag, "_dout_rdata"}, {sdram_dout, resp_rdata}, 0);
    chk({tag, "_ready_valid_done"}, 32'({req_ready, resp_valid, init_done}), 0);
  endtask
  task automatic run_init();
    logic [3:0] exp;
    int nresp = 0;
    for (int i = 1; i <= 42; i++) begin
      tick();
      exp = (i == 21) ? PRE : (i == 24 || i == 32) ? REF : (i == 40) ? MRS : NOP;
      chk("init_cmd", 32'(cmd), 32'(exp));
      if (resp_valid) nresp++;
      if (i == 1) chk("init_cke", 32'(sdram_cke), 1);
      if (i == 21) chk("init_pre_a10", 32'(sdram_a[10]), 1);
      if (i == 40) chk("init_mrs_a_ba", 32'({sdram_a, sdram_ba}), 32'({13'h020, 2'b00}));
      if (i == 42) chk("init_done_early", 32'({init_done, req_ready}), 0);
    end
    tick();
    chk("init_done_ready", 32'({init_done, req_ready}), 32'h3);
    chk("init_no_resp", nresp, 0);
    cyc_init = cyc;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(req_ready), 1);
  endtask
  task automatic xfer(input logic w, input logic [23:0] addr, input logic [15:0] data, input logic [1:0] mask);
    int t, n;
    wait_ready();
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = data; req_mask = mask;
    t = cyc;
    tick();
    req_valid = 1'b0;
    act_cmd = cmd; act_a = sdram_a; act_ba = sdram_ba;
    tick();
    tick();
    rw_cmd = cmd; rw_a = sdram_a; rw_dqm = sdram_dqm; rw_den = sdram_den; rw_dout = sdram_dout;
    dqm_during = sdram_dqm;
    lat = -1;
    if (!w) begin
      n = 0;
      while (!resp_valid && n < 10) begin
        tick();
        n++;
        if (!resp_valid) dqm_during = dqm_during | sdram_dqm;
      end
      lat = resp_valid ? cyc - t : -1;
      rd_val = resp_rdata;
      dqm_after = sdram_dqm;
    end
  endtask
  initial begin
    int t_ref, n, r0, nacc, nresp;
    int acc [$];
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    run_init();
    xfer(1'b1, 24'h123456, 16'hBEEF, 2'b11);
    chk("wr_act", 32'({act_cmd, act_a, act_ba}), 32'({ACT, 13'h0246, 2'd2}));
    chk("wr_cmd_a", 32'({rw_cmd, rw_a}), 32'({WR, 13'h0456}));
    chk("wr_den_dqm", 32'({rw_den, rw_dqm}), 32'({1'b1, 2'b00}));
    chk("wr_dout", 32'(rw_dout), 32'hBEEF);
    xfer(1'b0, 24'h123456, 16'h0000, 2'b11);
    chk("rd_cmd_a", 32'({rw_cmd, rw_a}), 32'({RD, 13'h0456}));
    chk("rd_dqm_during", 32'(dqm_during), 0);
    chk("rd_dqm_after", 32'(dqm_after), 32'h3);
    chk("rd_latency", lat, 6);
    chk("rd_data", 32'(rd_val), 32'hBEEF);
    xfer(1'b1, 24'h000010, 16'hFFFF, 2'b11);
    xfer(1'b1, 24'h000010, 16'h1234, 2'b01);
    chk("mask_dqm", 32'(rw_dqm), 32'h2);
    xfer(1'b0, 24'h000010, 16'h0000, 2'b11);
    chk("mask_data", 32'(rd_val), 32'hFF34);
    wait_ready();
    n = 0;
    while (req_ready && n < 400) begin
      tick();
      n++;
    end
    chk("ref_pend_cycle", cyc - cyc_init, RC);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000020;
    tick();
    chk("ref_first_cmd", 32'(cmd), 32'(REF));
    chk("ref_first_ready", 32'(req_ready), 0);
    t_ref = cyc;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ref_accept_delay", cyc - t_ref, 8);
    tick();
    req_valid = 1'b0;
    chk("ref_then_act", 32'(cmd), 32'(ACT));
    wait_ready();
    req_valid = 1'b1; req_addr = 24'h123456;
    nacc = 0; nresp = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) acc.push_back(cyc);
      if (resp_valid) nresp++;
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) nresp++;
      tick();
    end
    nacc = acc.size();
    chk("b2b_accepts", nacc, 5);
    for (int i = 1; i < nacc; i++) chk("b2b_spacing", acc[i] - acc[i-1], 8);
    chk("b2b_resps", nresp, nacc);
    r0 = n_ref;
    repeat (2000) tick();
    chk("ref_count_10pm1", 32'((n_ref - r0) >= 9 && (n_ref - r0) <= 11), 1);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h123456;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    tick();
    reset = 1'b0;
    run_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
